// File: rtl/sam_pkg.sv
// sam_pkg: shared state encoding, default widths and bit-duration select for the SAM link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sam_pkg;

    localparam int SAM_KEY_W   = 8;
    localparam int SAM_NLEN_W  = 4;
    localparam int SAM_CNT_W   = 5;
    localparam int SAM_GAP_CYC = 2;

    typedef enum logic [3:0] {
        IDLE,
        CFG_LEAD,
        CFG_N,
        CFG_D,
        CFG_CN,
        GAP,
        BIT_HI,
        BIT_LO,
        TERM,
        MSG_GAP
    } state_t;

    typedef struct packed {
        logic [SAM_CNT_W-1:0] h;
        logic [SAM_CNT_W-1:0] l;
    } dur_t;

    // A 1 bit is long-high/short-low; a 0 bit swaps the two phases.
    function automatic dur_t bit_dur(input logic b,
                                     input logic [SAM_CNT_W-1:0] hi_len,
                                     input logic [SAM_CNT_W-1:0] lo_len);
        dur_t r;
        r.h = b ? hi_len : lo_len;
        r.l = b ? lo_len : hi_len;
        return r;
    endfunction

endpackage

// File: rtl/sam_pulse_gen.sv
// sam_pulse_gen: one high-then-low pulse of h_len then l_len cycles per start strobe.
// Latency: hi_nxt/done come from flops only; a start may coincide with done for back-to-back bits.
// Backpressure: none; the caller only strobes start when idle or on done.
module sam_pulse_gen
    import sam_pkg::*;
#(
    parameter int CNT_W = SAM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] h_len,
    input  logic [CNT_W-1:0] l_len,
    output logic             hi_nxt,
    output logic             done
);

    logic             act_q, act_d;
    logic             hi_q, hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] l_q, l_d;

    always_comb begin
        act_d = act_q;
        hi_d  = hi_q;
        cnt_d = cnt_q;
        l_d   = l_q;
        if (act_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (hi_q) begin
                hi_d  = 1'b0;
                cnt_d = l_q - 1'b1;
            end else begin
                act_d = 1'b0;
            end
        end
        if (start) begin
            act_d = 1'b1;
            hi_d  = 1'b1;
            cnt_d = h_len - 1'b1;
            l_d   = l_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            act_q <= 1'b0;
            hi_q  <= 1'b0;
            cnt_q <= '0;
            l_q   <= '0;
        end else begin
            act_q <= act_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_d;
            l_q   <= l_d;
        end
    end

    // Level the line will take next cycle when no new start is issued.
    assign hi_nxt = act_q && hi_q && (cnt_q != '0);
    assign done   = act_q && !hi_q && (cnt_q == '0);

endmodule

// File: rtl/sam_link_sequencer.sv
// sam_link_sequencer: shifts n/d/N into SAM and sends pulse-width-coded messages; SAM_ERR_INJECT_EN adds err_inj.
// Latency: str/mode registered, first symbol on the line the cycle after the accepting edge.
// Backpressure: cfg_ready/msg_ready only in IDLE; config wins over a simultaneous message.
module sam_link_sequencer
    import sam_pkg::*;
#(
    parameter int KEY_W   = SAM_KEY_W,
    parameter int NLEN_W  = SAM_NLEN_W,
    parameter int CNT_W   = SAM_CNT_W,
    parameter int GAP_CYC = SAM_GAP_CYC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [NLEN_W-1:0]      cfg_n,
    input  logic [KEY_W-1:0]       cfg_d,
    input  logic [KEY_W-1:0]       cfg_caps_n,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [2**NLEN_W-2:0]   msg_data,
    input  logic [CNT_W-1:0]       hi_len,
    input  logic [CNT_W-1:0]       lo_len,
`ifdef SAM_ERR_INJECT_EN
    input  logic                   err_inj,
`endif
    output logic                   str,
    output logic                   mode,
    output logic                   configured,
    output logic                   busy,
    output logic                   msg_done,
    output logic                   msg_err
);

    localparam int MSG_W = 2**NLEN_W - 1;
    localparam int CFG_W = NLEN_W + 2*KEY_W;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CFG_W-1:0]  sr_q, sr_d;
    logic [NLEN_W-1:0] n_q, n_d;
    logic [NLEN_W-1:0] idx_q, idx_d;
    logic [MSG_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic [CNT_W-1:0]  lo_q, lo_d;
    logic              configured_q, configured_d;
    logic              str_q, str_d;
    logic              mode_q, mode_d;
    logic              msg_done_q, msg_done_d;
    logic              msg_err_q, msg_err_d;
    logic              pg_start, pg_hi_nxt, pg_done;
    dur_t              pg_dur;

    assign cfg_ready  = (state_q == IDLE);
    assign msg_ready  = (state_q == IDLE) && configured_q && !cfg_valid;
    assign busy       = (state_q != IDLE);
    assign str        = str_q;
    assign mode       = mode_q;
    assign configured = configured_q;
    assign msg_done   = msg_done_q;
    assign msg_err    = msg_err_q;

    sam_pulse_gen #(.CNT_W(CNT_W)) u_pulse (
        .clk    (clk),
        .reset  (reset),
        .start  (pg_start),
        .h_len  (pg_dur.h),
        .l_len  (pg_dur.l),
        .hi_nxt (pg_hi_nxt),
        .done   (pg_done)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        n_d          = n_q;
        idx_d        = idx_q;
        data_d       = data_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        configured_d = configured_q;
        str_d        = 1'b0;
        mode_d       = 1'b0;
        msg_done_d   = 1'b0;
        msg_err_d    = 1'b0;
        pg_start     = 1'b0;
        pg_dur       = bit_dur(1'b0, hi_q, lo_q);
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d      = CFG_LEAD;
                    mode_d       = 1'b1;
                    sr_d         = {cfg_n, cfg_d, cfg_caps_n};
                    cnt_d        = CNT_W'(NLEN_W - 1);
                    n_d          = cfg_n;
                    configured_d = 1'b0;
                end else if (msg_valid && msg_ready) begin
                    if ((lo_len == '0) || (hi_len <= lo_len)) begin
                        msg_err_d = 1'b1;
                    end else begin
                        data_d = msg_data;
                        hi_d   = hi_len;
                        lo_d   = lo_len;
                        str_d  = 1'b1;
                        if (n_q == '0) begin
                            state_d = TERM;
                        end else begin
                            state_d  = BIT_HI;
                            idx_d    = n_q - 1'b1;
                            pg_start = 1'b1;
                            pg_dur   = bit_dur(msg_data[n_q - 1'b1], hi_len, lo_len);
`ifdef SAM_ERR_INJECT_EN
                            if (err_inj) begin
                                pg_dur = '{h: hi_len, l: hi_len};
                            end
`endif
                        end
                    end
                end
            end
            CFG_LEAD: begin
                state_d = CFG_N;
                mode_d  = 1'b1;
                str_d   = sr_q[CFG_W-1];
                sr_d    = sr_q << 1;
            end
            CFG_N, CFG_D, CFG_CN: begin
                mode_d = 1'b1;
                str_d  = sr_q[CFG_W-1];
                sr_d   = sr_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(KEY_W - 1);
                    if (state_q == CFG_N) begin
                        state_d = CFG_D;
                    end else if (state_q == CFG_D) begin
                        state_d = CFG_CN;
                    end else begin
                        state_d = GAP;
                        mode_d  = 1'b0;
                        str_d   = 1'b0;
                        sr_d    = sr_q;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    configured_d = 1'b1;
                end
            end
            BIT_HI, BIT_LO: begin
                // A finished bit either chains straight into the next bit or into the terminator.
                if (pg_done) begin
                    str_d = 1'b1;
                    if (idx_q == '0) begin
                        state_d = TERM;
                    end else begin
                        state_d  = BIT_HI;
                        idx_d    = idx_q - 1'b1;
                        pg_start = 1'b1;
                        pg_dur   = bit_dur(data_q[idx_q - 1'b1], hi_q, lo_q);
                    end
                end else begin
                    str_d   = pg_hi_nxt;
                    state_d = pg_hi_nxt ? BIT_HI : BIT_LO;
                end
            end
            TERM: begin
                state_d = MSG_GAP;
                cnt_d   = CNT_W'(GAP_CYC - 1);
            end
            MSG_GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    msg_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            configured_q <= 1'b0;
            str_q        <= 1'b0;
            mode_q       <= 1'b0;
            msg_done_q   <= 1'b0;
            msg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            configured_q <= configured_d;
            str_q        <= str_d;
            mode_q       <= mode_d;
            msg_done_q   <= msg_done_d;
            msg_err_q    <= msg_err_d;
        end
    end

endmodule

// File: tb/tb_sam_link_sequencer.sv
// tb_sam_link_sequencer: directed scoreboard bench; expected {busy,mode,str,done,err} per cycle queued at accept.
// Latency: monitor compares every cycle while the queue holds expectations, flags any activity otherwise.
// Backpressure: stimulus waits on cfg_ready/msg_ready with bounded loops.
module tb_sam_link_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_ready;
    logic [3:0]  cfg_n;
    logic [7:0]  cfg_d, cfg_caps_n;
    logic        msg_valid, msg_ready;
    logic [14:0] msg_data;
    logic [4:0]  hi_len, lo_len;
    logic        str, mode, configured, busy, msg_done, msg_err;
`ifdef SAM_ERR_INJECT_EN
    logic        err_inj = 1'b0;
`endif

    always #5 clk = ~clk;

    sam_link_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_n      (cfg_n),
        .cfg_d      (cfg_d),
        .cfg_caps_n (cfg_caps_n),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_data   (msg_data),
        .hi_len     (hi_len),
        .lo_len     (lo_len),
`ifdef SAM_ERR_INJECT_EN
        .err_inj    (err_inj),
`endif
        .str        (str),
        .mode       (mode),
        .configured (configured),
        .busy       (busy),
        .msg_done   (msg_done),
        .msg_err    (msg_err)
    );

    int         checks = 0;
    int         errors = 0;
    int         rec_idx = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_got, mon_exp;

    // Record layout {busy, mode, str, msg_done, msg_err}.
    function automatic void push(input logic [4:0] r);
        exp_q.push_back(r);
    endfunction

    function automatic void push_cfg(input logic [3:0] n, input logic [7:0] d, input logic [7:0] cn);
        logic [19:0] bits;
        bits = {n, d, cn};
        push(5'b11000);
        for (int i = 19; i >= 0; i--) push({2'b11, bits[i], 2'b00});
        push(5'b10000);
        push(5'b10000);
    endfunction

    function automatic void push_msg(input int n, input logic [14:0] data, input int hi, input int lo);
        for (int i = n - 1; i >= 0; i--) begin
            int h, l;
            h = data[i] ? hi : lo;
            l = data[i] ? lo : hi;
            repeat (h) push(5'b10100);
            repeat (l) push(5'b10000);
        end
        push(5'b10100);
        push(5'b10000);
        push(5'b10000);
        push(5'b00010);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_got = {busy, mode, str, msg_done, msg_err};
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL trace rec %0d got busy/mode/str/done/err=%b required %b",
                             rec_idx, mon_got, mon_exp);
                end
                rec_idx++;
            end else if ((|mon_got) === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %b required 00000", mon_got);
            end
        end
    end

    task automatic drain();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || busy) && t < 3000);
        chk("drain_timeout", int'(t >= 3000), 0);
    endtask

    task automatic do_cfg(input logic [3:0] n, input logic [7:0] d, input logic [7:0] cn, input int keep);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_n = n; cfg_d = d; cfg_caps_n = cn;
        chk("cfg_ready", int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        push_cfg(n, d, cn);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
    endtask

    task automatic do_msg(input int n, input logic [14:0] data, input int hi, input int lo, input bit ok);
        @(negedge clk);
        msg_valid = 1'b1; msg_data = data; hi_len = 5'(hi); lo_len = 5'(lo);
        chk("msg_ready", int'(msg_ready), 1);
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        if (ok) push_msg(n, data, hi, lo);
        else push(5'b00001);
    endtask

    initial begin
        int w;
        reset = 1'b0; cfg_valid = 1'b0; msg_valid = 1'b0;
        cfg_n = '0; cfg_d = '0; cfg_caps_n = '0; msg_data = '0; hi_len = '0; lo_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_str", int'(str), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_configured", int'(configured), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_err", int'({msg_done, msg_err}), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_msg_ready", int'(msg_ready), 0);
        reset = 1'b1;

        msg_valid = 1'b1; msg_data = 15'h7; hi_len = 5'd8; lo_len = 5'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("unconfigured_msg_ready", int'(msg_ready), 0);
        end
        msg_valid = 1'b0;

        do_cfg(4'd3, 8'hFF, 8'hFF, 23);
        drain();
        chk("configured_after_cfg", int'(configured), 1);

        do_msg(3, 15'b101, 12, 5, 1'b1);
        drain();
        do_msg(3, 15'b101, 5, 5, 1'b0);
        drain();
        chk("reject_busy", int'(busy), 0);
        do_msg(3, 15'b011, 4, 0, 1'b0);
        drain();

        do_cfg(4'd3, 8'hA5, 8'h3C, 9);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_str", int'(str), 0);
        chk("midrst_configured", int'(configured), 0);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b1;

        do_cfg(4'd2, 8'h5A, 8'hC3, 23);
        drain();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_n = 4'd2; cfg_d = 8'h0F; cfg_caps_n = 8'hF0;
        msg_valid = 1'b1; msg_data = 15'b01; hi_len = 5'd4; lo_len = 5'd2;
        #1;
        chk("arb_cfg_ready", int'(cfg_ready), 1);
        chk("arb_msg_masked", int'(msg_ready), 0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        push_cfg(4'd2, 8'h0F, 8'hF0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!msg_ready && w < 100);
        chk("arb_msg_wait", w, 24);
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        push_msg(2, 15'b01, 4, 2);
        drain();

        do_cfg(4'd0, 8'h01, 8'h80, 23);
        drain();
        do_msg(0, 15'h7FFF, 9, 3, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
